// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one FIFO write port among N producers.
// Define FIFO_PUSH_ARB_BURST_EN to let a winner hold the port for up to MAX_BURST writes.
module fifo_push_arb #(
   parameter int unsigned N         = 4,
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           req,
   input  logic [N*WIDTH-1:0]     wdata_in,
   input  logic                   full,
   output logic [N-1:0]           gnt,
   output logic                   push,
   output logic [WIDTH-1:0]       wdata,
   output logic [$clog2(N)-1:0]   owner,
   output logic                   lock
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(MAX_BURST) + 1;

   logic [IW-1:0]    last_q, last_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    win_c;
   logic             found_c;
   logic             lock_cur_c;
   logic [N-1:0]     gnt_c;
   logic [WIDTH-1:0] wdata_c;

`ifdef FIFO_PUSH_ARB_BURST_EN
   logic          lock_q, lock_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;

   assign lock_cur_c = lock_q;
`else
   logic unused_max_burst;

   assign lock_cur_c       = 1'b0;
   assign unused_max_burst = (CW == 0);
`endif

   // Winner selection: locked owner first, else circular scan starting after last.
   always_comb begin
      logic [IW-1:0] cand;
      int unsigned   sum;
      win_c   = last_q;
      found_c = 1'b0;
      cand    = '0;
      sum     = 0;
      if (rst_n && !full) begin
         if (lock_cur_c && req[last_q]) begin
            win_c   = last_q;
            found_c = 1'b1;
         end else begin
            for (int unsigned k = 1; k <= N; k++) begin
               sum = 32'(last_q) + k;
               if (sum >= N) sum = sum - N;
               cand = IW'(sum);
               if (!found_c && req[cand]) begin
                  win_c   = cand;
                  found_c = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      gnt_c   = '0;
      wdata_c = '0;
      if (found_c) gnt_c[win_c] = 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt_c[i]) wdata_c = wdata_c | wdata_in[i*WIDTH +: WIDTH];
      end
   end

   assign gnt   = gnt_c;
   assign push  = |gnt_c;
   assign wdata = wdata_c;
   assign owner = owner_q;

   always_comb begin
      last_d  = last_q;
      if (found_c) last_d = win_c;
      owner_d = last_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= IW'(N - 1);
         owner_q <= '0;
      end else begin
         last_q  <= last_d;
         owner_q <= owner_d;
      end
   end

`ifdef FIFO_PUSH_ARB_BURST_EN
   // Burst bookkeeping: count consecutive grants to the same locked owner.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      lock_d      = lock_q;
      if (found_c) begin
         if (lock_q && (win_c == last_q)) burst_cnt_d = burst_cnt_q + CW'(1);
         else                             burst_cnt_d = CW'(1);
         lock_d = (32'(burst_cnt_d) < MAX_BURST);
      end else if (!full && lock_q && !req[last_q]) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q      <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         lock_q      <= lock_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign lock = lock_q;
`else
   assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: directed vector table, reset corners, random vs. model.
module tb_fifo_push_arb;

   localparam int unsigned N         = 4;
   localparam int unsigned WIDTH     = 16;
   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned IW        = 2;
`ifdef FIFO_PUSH_ARB_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N-1:0]         req;
   logic [N*WIDTH-1:0]   wdata_in;
   logic                 full;
   logic [N-1:0]         gnt;
   logic                 push;
   logic [WIDTH-1:0]     wdata;
   logic [IW-1:0]        owner;
   logic                 lock;

   int cmp_cnt = 0;
   int err_cnt = 0;

   fifo_push_arb #(.N(N), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .wdata_in(wdata_in), .full(full),
      .gnt(gnt), .push(push), .wdata(wdata), .owner(owner), .lock(lock)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  req;
      logic          full;
      logic [N-1:0]  gnt;
      logic [IW-1:0] owner;
      logic          lock;
   } vec_t;

   vec_t tbl[$];

   // Reference model state: last winner, consecutive-grant count, lock flag.
   int m_last;
   int m_cnt;
   bit m_lock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [N-1:0] r, input logic f, input logic [N-1:0] g,
                               input logic [IW-1:0] o, input logic l);
      vec_t v;
      v.req = r; v.full = f; v.gnt = g; v.owner = o; v.lock = l;
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] sel_data(input logic [N-1:0] g, input logic [N*WIDTH-1:0] wd);
      for (int i = 0; i < N; i++) if (g[i]) return wd[i*WIDTH +: WIDTH];
      return '0;
   endfunction

   function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r, input logic f);
      logic [N-1:0] one;
      one = 1;
      if (f) return '0;
      if (m_lock && r[m_last]) return one << m_last;
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (m_last + k) % N;
         if (r[i]) return one << i;
      end
      return '0;
   endfunction

   task automatic model_update(input logic [N-1:0] g, input logic f);
      int w;
      if (g != 0) begin
         w = 0;
         for (int i = 0; i < N; i++) if (g[i]) w = i;
         if (BURST && m_lock && w == m_last) m_cnt++;
         else m_cnt = 1;
         m_lock = BURST && (m_cnt < MAX_BURST);
         m_last = w;
      end else if (!f) begin
         m_lock = 1'b0;
      end
   endtask

   function automatic logic [N*WIDTH-1:0] rnd_data();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      logic [N-1:0] eg;
`ifdef FIFO_PUSH_ARB_BURST_EN
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b0));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b0));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1));
      tbl.push_back(mk(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1));
      tbl.push_back(mk(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1));
`else
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(4'b1111, 1'b0, 4'(1 << (i % 4)), IW'(i % 4), 1'b0));
      tbl.push_back(mk(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b0));
      tbl.push_back(mk(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b0));
      tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0));
      tbl.push_back(mk(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0));
      tbl.push_back(mk(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0));
`endif

      // Reset behaviour with all requesters active.
      rst_n = 1'b0; req = 4'b1111; full = 1'b0; wdata_in = rnd_data();
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_push", 64'(push), 64'(0));
      check("rst_owner", 64'(owner), 64'(0));
      check("rst_lock", 64'(lock), 64'(0));
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         req = tbl[i].req; full = tbl[i].full; wdata_in = rnd_data();
         #3;
         check($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
         check($sformatf("tbl%0d_push", i), 64'(push), 64'(tbl[i].gnt != 0));
         check($sformatf("tbl%0d_wdata", i), 64'(wdata), 64'(sel_data(tbl[i].gnt, wdata_in)));
         @(posedge clk); #1;
         check($sformatf("tbl%0d_owner", i), 64'(owner), 64'(tbl[i].owner));
         check($sformatf("tbl%0d_lock", i), 64'(lock), 64'(tbl[i].lock));
      end

      // Requester 3 builds a burst, then reset is pulsed mid-burst.
      req = 4'b1000; full = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #3;
         check("r3_gnt", 64'(gnt), 64'(4'b1000));
         @(posedge clk); #1;
      end
      check("r3_lock", 64'(lock), 64'(BURST));
      check("r3_owner", 64'(owner), 64'(3));
      #1 rst_n = 1'b0;
      #1;
      check("midrst_lock", 64'(lock), 64'(0));
      check("midrst_gnt", 64'(gnt), 64'(0));
      check("midrst_push", 64'(push), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; req = 4'b1001; wdata_in = rnd_data();
      #2;
      check("postrst_gnt", 64'(gnt), 64'(4'b0001));
      check("postrst_wdata", 64'(wdata), 64'(wdata_in[15:0]));
      @(posedge clk); #1;
      check("postrst_owner", 64'(owner), 64'(0));

      // Randomised traffic against the reference model.
      rst_n = 1'b0; #1; rst_n = 1'b1;
      m_last = N - 1; m_cnt = 0; m_lock = 1'b0;
      req = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         full = ($urandom_range(0, 5) == 0);
         wdata_in = rnd_data();
         #3;
         eg = model_gnt(req, full);
         check("rnd_gnt", 64'(gnt), 64'(eg));
         check("rnd_push", 64'(push), 64'(eg != 0));
         check("rnd_wdata", 64'(wdata), 64'(sel_data(eg, wdata_in)));
         @(posedge clk); #1;
         model_update(eg, full);
         check("rnd_owner", 64'(owner), 64'(m_last));
         check("rnd_lock", 64'(lock), 64'(m_lock));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
